// File: rtl/irq_scheduler_if.sv
// Data-memory bus between the MEM stage and the timer/IRQ block.
// Signals: addr, wdata, mem_wr, mem_rd (master->slave); rdata (slave->master).
interface irq_scheduler_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] rdata;

    modport master (
        output addr, wdata, mem_wr, mem_rd,
        input  rdata
    );

    modport slave (
        input  addr, wdata, mem_wr, mem_rd,
        output rdata
    );
endinterface

// File: rtl/irq_scheduler.sv
// Timer (TH/TL/TCON) plus interrupt injection FSM for the decode stage.
// Ports: clk, reset (sync, high), bus (slave), kernel, id_branch, id_jump,
//        stall, eret in; IRQ (one-cycle pulse), irq_busy out.
module irq_scheduler (
    input  logic            clk,
    input  logic            reset,
    irq_scheduler_if.slave  bus,
    input  logic            kernel,
    input  logic            id_branch,
    input  logic            id_jump,
    input  logic            stall,
    input  logic            eret,
    output logic            IRQ,
    output logic            irq_busy
);
    localparam logic [31:0] ADDR_TH   = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL   = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON = 32'h4000_0008;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        FIRE    = 2'd2,
        SERVICE = 2'd3
    } state_t;

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    state_t      state;

    logic selTh, selTl, selTcon;
    logic wrTh, wrTl, wrTcon;
    logic overflow, ovSet;
    logic slotFree, armed;

    assign selTh   = (bus.addr == ADDR_TH);
    assign selTl   = (bus.addr == ADDR_TL);
    assign selTcon = (bus.addr == ADDR_TCON);

    assign wrTh   = bus.mem_wr && selTh;
    assign wrTl   = bus.mem_wr && selTl;
    assign wrTcon = bus.mem_wr && selTcon;

    assign overflow = tcon[0] && (tl == 32'hFFFF_FFFF);
    assign ovSet    = overflow && tcon[1];

    assign armed    = tcon[2] && tcon[1];
    // Only inject into an ordinary user-mode slot: no delay slot, no bubble.
    assign slotFree = !stall && !id_branch && !id_jump && !kernel;

    always_comb begin
        bus.rdata = 32'd0;
        if (bus.mem_rd) begin
            unique case (1'b1)
                selTh:   bus.rdata = th;
                selTl:   bus.rdata = tl;
                selTcon: bus.rdata = {29'd0, tcon};
                default: bus.rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= 32'd0;
            tl   <= 32'd0;
            tcon <= 3'd0;
        end else begin
            if (wrTh)
                th <= bus.wdata;

            if (wrTl)
                tl <= bus.wdata;
            else if (overflow)
                tl <= th;
            else if (tcon[0])
                tl <= tl + 32'd1;

            // Status is sticky: a concurrent write cannot drop an overflow.
            if (wrTcon)
                tcon <= {bus.wdata[2] | ovSet, bus.wdata[1:0]};
            else if (ovSet)
                tcon[2] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:
                    if (armed && !kernel)
                        state <= WAIT;
                WAIT:
                    if (!armed)
                        state <= IDLE;
                    else if (slotFree)
                        state <= FIRE;
                FIRE:
                    state <= SERVICE;
                SERVICE:
                    if (eret)
                        state <= IDLE;
                default:
                    state <= IDLE;
            endcase
        end
    end

    assign IRQ      = (state == FIRE);
    assign irq_busy = (state != IDLE);
endmodule
